// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to the pixel generator and the CPU side.
interface vga_timing_if;
  logic [15:0] pixel_col;
  logic [15:0] pixel_row;
  logic        active;
  logic        hsync_n;
  logic        vsync_n;
  logic        blank;
  logic        frame_start;
  logic        vblank_irq;
  logic [7:0]  frame_count;

  modport master (
    output pixel_col, pixel_row, active, hsync_n, vsync_n, blank,
           frame_start, vblank_irq, frame_count
  );

  modport slave (
    input  pixel_col, pixel_row, active, hsync_n, vsync_n, blank,
           frame_start, vblank_irq, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters with undelayed col/row/active and registered frame/vblank pulses;
// hsync_n/vsync_n/blank lag the counters by PIPE_DELAY cycles to line up with pixel data.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic         pixel_clk,
  input  logic         data_reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] HS_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [15:0] col;
  logic [15:0] row;
  logic [15:0] col_nxt;
  logic [15:0] row_nxt;
  logic        col_last;
  logic        row_last;
  logic        frame_start;
  logic        vblank_irq;
  logic [7:0]  frame_count;

  assign col_last = (col == H_LAST);
  assign row_last = (row == V_LAST);

  always_comb begin
    col_nxt = col + 16'd1;
    row_nxt = row;
    if (col_last) begin
      col_nxt = 16'd0;
      row_nxt = row_last ? 16'd0 : row + 16'd1;
    end
  end

  // Pulses are decoded from the next counter value so they are high exactly
  // while the counters themselves read the trigger position.
  always_ff @(posedge pixel_clk) begin
    if (data_reset) begin
      col         <= 16'd0;
      row         <= 16'd0;
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      col         <= col_nxt;
      row         <= row_nxt;
      frame_start <= (col_nxt == 16'd0) && (row_nxt == 16'd0);
      vblank_irq  <= (col_nxt == 16'd0) && (row_nxt == V_VIS);
      if (col_last && row_last)
        frame_count <= frame_count + 8'd1;
    end
  end

  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] raw_bits;
  logic [2:0] dly_out;

  assign active   = (col < H_VIS) && (row < V_VIS);
  assign hs_raw   = !((col >= HS_START) && (col < HS_END));
  assign vs_raw   = !((row >= VS_START) && (row < VS_END));
  assign raw_bits = {hs_raw, vs_raw, !active};

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign dly_out = raw_bits;
    end else begin : g_dly
      logic [2:0] stage [PIPE_DELAY];

      // All stages reset to the idle pattern so no stale sync leaks out after reset.
      always_ff @(posedge pixel_clk) begin
        if (data_reset) begin
          for (int i = 0; i < PIPE_DELAY; i++)
            stage[i] <= 3'b111;
        end else begin
          stage[0] <= raw_bits;
          for (int i = 1; i < PIPE_DELAY; i++)
            stage[i] <= stage[i-1];
        end
      end

      assign dly_out = stage[PIPE_DELAY-1];
    end
  endgenerate

  assign vga.pixel_col   = col;
  assign vga.pixel_row   = row;
  assign vga.active      = active;
  assign vga.hsync_n     = dly_out[2];
  assign vga.vsync_n     = dly_out[1];
  assign vga.blank       = dly_out[0];
  assign vga.frame_start = frame_start;
  assign vga.vblank_irq  = vblank_irq;
  assign vga.frame_count = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks: instance A keeps the default horizontal timing with a short frame
// (V 8/2/2/3, 12000 cycles) and PIPE_DELAY=2; instance B is a tiny raster with PIPE_DELAY=0.
module tb_vga_timing_gen;
  logic pixel_clk = 1'b0;
  logic rst_a     = 1'b1;
  logic rst_b     = 1'b1;
  int   n_chk     = 0;
  int   n_err     = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_if bus_a ();
  vga_timing_if bus_b ();

  vga_timing_gen #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(8),   .V_FRONT(2),  .V_SYNC(2),  .V_BACK(3),
    .PIPE_DELAY(2)
  ) dut_a (
    .pixel_clk (pixel_clk),
    .data_reset(rst_a),
    .vga       (bus_a.master)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIPE_DELAY(0)
  ) dut_b (
    .pixel_clk (pixel_clk),
    .data_reset(rst_b),
    .vga       (bus_b.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pixel_clk);
      #1;
    end
  endtask

  task automatic wait_pos(input bit use_b, input int c, input int r, input string tag);
    int n = 0;
    while (n < 15000 &&
           !(((use_b ? bus_b.pixel_col : bus_a.pixel_col) == 16'(c)) &&
             ((use_b ? bus_b.pixel_row : bus_a.pixel_row) == 16'(r)))) begin
      tick();
      n++;
    end
    check({tag, "_reached"}, 32'(n < 15000), 1);
  endtask

  initial begin
    int lows;
    int n;

    // Reset state
    tick(3);
    check("rst_col",   bus_a.pixel_col,   0);
    check("rst_row",   bus_a.pixel_row,   0);
    check("rst_hs",    bus_a.hsync_n,     1);
    check("rst_vs",    bus_a.vsync_n,     1);
    check("rst_blank", bus_a.blank,       1);
    check("rst_fs",    bus_a.frame_start, 0);
    check("rst_vb",    bus_a.vblank_irq,  0);
    check("rst_fc",    bus_a.frame_count, 0);
    check("rst_b_fc",  bus_b.frame_count, 0);
    rst_a = 1'b0;
    tick();
    check("first_col", bus_a.pixel_col, 1);

    // Blank and hsync along row 0, two cycles late
    wait_pos(0, 640, 0, "h640");
    check("blank_640", bus_a.blank, 0);
    tick();
    check("blank_641", bus_a.blank, 0);
    tick();
    check("blank_642", bus_a.blank, 1);
    lows = 0;
    n = 0;
    while (bus_a.pixel_col != 16'd799 && n < 1000) begin
      if (bus_a.pixel_col == 16'd657) check("hs_657", bus_a.hsync_n, 1);
      if (bus_a.pixel_col == 16'd658) check("hs_658", bus_a.hsync_n, 0);
      if (bus_a.pixel_col == 16'd753) check("hs_753", bus_a.hsync_n, 0);
      if (bus_a.pixel_col == 16'd754) check("hs_754", bus_a.hsync_n, 1);
      if (!bus_a.hsync_n) lows++;
      tick();
      n++;
    end
    check("hs_width", lows, 96);
    tick();
    check("wrap0_col", bus_a.pixel_col, 0);
    check("wrap0_row", bus_a.pixel_row, 1);

    // Line wrap row 5 -> 6
    wait_pos(0, 799, 5, "l5end");
    tick();
    check("wrap5_col", bus_a.pixel_col, 0);
    check("wrap5_row", bus_a.pixel_row, 6);
    check("act_0_6",   bus_a.active,    1);
    wait_pos(0, 639, 6, "c639");
    check("act_639_6", bus_a.active, 1);
    tick();
    check("act_640_6", bus_a.active, 0);

    // Vblank pulse and vsync width
    wait_pos(0, 799, 7, "l7end");
    check("vb_before", bus_a.vblank_irq, 0);
    tick();
    check("vb_pulse",  bus_a.vblank_irq, 1);
    check("act_0_8",   bus_a.active,     0);
    tick();
    check("vb_after",  bus_a.vblank_irq, 0);
    wait_pos(0, 0, 10, "vs_row");
    check("vs_0_10", bus_a.vsync_n, 1);
    tick();
    check("vs_1_10", bus_a.vsync_n, 1);
    tick();
    check("vs_2_10", bus_a.vsync_n, 0);
    n = 0;
    while (!bus_a.vsync_n && n < 2000) begin
      tick();
      n++;
    end
    check("vs_width", n, 1600);

    // Frame wrap and frame length
    wait_pos(0, 799, 14, "fend");
    check("fs_before", bus_a.frame_start, 0);
    check("fc_before", bus_a.frame_count, 0);
    tick();
    check("fwrap_col", bus_a.pixel_col,   0);
    check("fwrap_row", bus_a.pixel_row,   0);
    check("fs_pulse",  bus_a.frame_start, 1);
    check("fc_one",    bus_a.frame_count, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_a.frame_start && n < 13000);
    check("frame_len", n, 12000);
    check("fc_two", bus_a.frame_count, 2);

    // Reset mid-frame
    wait_pos(0, 300, 5, "mid");
    rst_a = 1'b1;
    tick();
    check("mr_col",   bus_a.pixel_col,   0);
    check("mr_row",   bus_a.pixel_row,   0);
    check("mr_hs",    bus_a.hsync_n,     1);
    check("mr_vs",    bus_a.vsync_n,     1);
    check("mr_blank", bus_a.blank,       1);
    check("mr_fs",    bus_a.frame_start, 0);
    check("mr_fc",    bus_a.frame_count, 0);
    rst_a = 1'b0;
    tick();
    check("mr1_col",   bus_a.pixel_col, 1);
    check("mr1_blank", bus_a.blank,     1);
    tick();
    check("mr2_blank", bus_a.blank,     0);
    wait_pos(0, 799, 14, "mr_fend");
    tick();
    check("mr_fs_pulse", bus_a.frame_start, 1);
    check("mr_fc_one",   bus_a.frame_count, 1);

    // Small raster, zero pipe delay, frame_count wrap
    rst_b = 1'b0;
    tick();
    wait_pos(1, 3, 0, "b3");
    check("b_blank_3", bus_b.blank,   0);
    check("b_hs_3",    bus_b.hsync_n, 1);
    tick();
    check("b_blank_4", bus_b.blank,   1);
    check("b_hs_4",    bus_b.hsync_n, 1);
    tick();
    check("b_hs_5",    bus_b.hsync_n, 0);
    tick();
    check("b_hs_6",    bus_b.hsync_n, 0);
    tick();
    check("b_hs_7",    bus_b.hsync_n, 1);
    wait_pos(1, 0, 2, "b_r2");
    check("b_vs_r2", bus_b.vsync_n, 1);
    wait_pos(1, 0, 3, "b_r3");
    check("b_vs_r3", bus_b.vsync_n, 0);
    n = 0;
    while (bus_b.frame_count != 8'd255 && n < 12000) begin
      tick();
      n++;
    end
    check("b_fc_reach", 32'(n < 12000), 1);
    wait_pos(1, 7, 4, "b_fend");
    check("b_fc_255",  bus_b.frame_count, 255);
    tick();
    check("b_fc_wrap", bus_b.frame_count, 0);
    check("b_fs",      bus_b.frame_start, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
